// File: rtl/serial_paralelo_param_pkg.sv
// Shared definitions for the serial-to-parallel deserializer: FSM state encoding
// and the default alignment symbol.
package serial_paralelo_param_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    localparam logic [7:0] COMMA_DEFAULT = 8'hBC;

endpackage

// File: rtl/sp_comma_det.sv
// Serial shift register plus a bit-granular comparator against the comma symbol.
// Exposes the value the register is about to load so the FSM can act on the same edge.
module sp_comma_det
    import serial_paralelo_param_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] COMMA = WIDTH'(COMMA_DEFAULT)
) (
    input  logic             clk_32f,
    input  logic             reset_L,
    input  logic             data_input,
    output logic [WIDTH-1:0] next_sr,
    output logic             is_comma
);

    // The oldest bit is shifted out on the same edge it would be loaded, so only
    // the WIDTH-1 youngest bits need storage.
    logic [WIDTH-2:0] sr;

    assign next_sr  = {sr, data_input};
    assign is_comma = (next_sr == COMMA);

    // NOTE: sequential state uses non-blocking assignment so every register samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            sr <= '0;
        end else begin
            sr <= next_sr[WIDTH-2:0];
        end
    end

endmodule

// File: rtl/serial_paralelo_param.sv
// Comma-aligned serial-to-parallel converter: hunts for COMMA, requires LOCK_COUNT
// aligned commas to lock, then emits every non-comma word with a one-cycle strobe.
module serial_paralelo_param
    import serial_paralelo_param_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] COMMA      = WIDTH'(COMMA_DEFAULT),
    parameter int               LOCK_COUNT = 4
) (
    input  logic             clk_32f,
    input  logic             reset_L,
    input  logic             data_input,
    output logic [WIDTH-1:0] data_output,
    output logic             valid_out,
    output logic             active,
    output logic [3:0]       BC_contador
);

    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);
    localparam logic [3:0]     LOCK     = 4'(LOCK_COUNT);

    logic [WIDTH-1:0] next_sr;
    logic             is_comma;

    sp_comma_det #(
        .WIDTH (WIDTH),
        .COMMA (COMMA)
    ) u_comma_det (
        .clk_32f    (clk_32f),
        .reset_L    (reset_L),
        .data_input (data_input),
        .next_sr    (next_sr),
        .is_comma   (is_comma)
    );

    state_t           state, state_nx;
    logic [CW-1:0]    bit_cnt, bit_cnt_nx;
    logic [WIDTH-1:0] data_nx;
    logic             valid_nx;
    logic             active_nx;
    logic [3:0]       bc_nx;
    logic             boundary;

    // Edge that samples the last bit of an aligned word.
    assign boundary = (bit_cnt == LAST_BIT);

    // NOTE: every signal driven here gets a default first, so no path can leave one
    // unassigned and infer a latch.
    always_comb begin
        state_nx   = state;
        bit_cnt_nx = boundary ? '0 : bit_cnt + 1'b1;
        data_nx    = data_output;
        valid_nx   = 1'b0;
        active_nx  = active;
        bc_nx      = BC_contador;

        case (state)
            SEARCH: begin
                bit_cnt_nx = '0;
                if (is_comma) begin
                    bc_nx = 4'd1;
                    if (LOCK_COUNT == 1) begin
                        state_nx  = ACTIVE;
                        active_nx = 1'b1;
                    end else begin
                        state_nx = ALIGN;
                    end
                end
            end
            ALIGN: begin
                if (boundary) begin
                    if (is_comma) begin
                        bc_nx = BC_contador + 4'd1;
                        if (bc_nx == LOCK) begin
                            state_nx  = ACTIVE;
                            active_nx = 1'b1;
                        end
                    end else begin
                        state_nx = SEARCH;
                        bc_nx    = 4'd0;
                    end
                end
            end
            ACTIVE: begin
                // Commas are idle fill once locked; misaligned comma patterns never matter here.
                if (boundary) begin
                    if (is_comma) begin
                        bc_nx = LOCK;
                    end else begin
                        data_nx  = next_sr;
                        valid_nx = 1'b1;
                    end
                end
            end
            default: begin
                state_nx = SEARCH;
            end
        endcase
    end

    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            state       <= SEARCH;
            bit_cnt     <= '0;
            data_output <= '0;
            valid_out   <= 1'b0;
            active      <= 1'b0;
            BC_contador <= 4'd0;
        end else begin
            state       <= state_nx;
            bit_cnt     <= bit_cnt_nx;
            data_output <= data_nx;
            valid_out   <= valid_nx;
            active      <= active_nx;
            BC_contador <= bc_nx;
        end
    end

endmodule

// File: tb/tb_serial_paralelo_param.sv
// Self-checking bench: directed lock/data scenarios, a randomized stream checked
// against a bit-history reference model, and a WIDTH=10 single-comma-lock instance.
module tb_serial_paralelo_param;

    localparam int         W    = 8;
    localparam logic [7:0] BC   = 8'hBC;
    localparam int         LOCK = 4;

    logic       clk_32f = 1'b0;
    logic       reset_L = 1'b1;
    logic       din     = 1'b0;
    logic       din10   = 1'b0;

    logic [7:0] dout;
    logic       valid;
    logic       act;
    logic [3:0] bc;
    logic [9:0] dout10;
    logic       valid10;
    logic       act10;
    logic [3:0] bc10;

    always #5 clk_32f = ~clk_32f;

    serial_paralelo_param #(.WIDTH(8), .COMMA(8'hBC), .LOCK_COUNT(4)) dut (
        .clk_32f     (clk_32f),
        .reset_L     (reset_L),
        .data_input  (din),
        .data_output (dout),
        .valid_out   (valid),
        .active      (act),
        .BC_contador (bc)
    );

    serial_paralelo_param #(.WIDTH(10), .COMMA(10'h17C), .LOCK_COUNT(1)) dut10 (
        .clk_32f     (clk_32f),
        .reset_L     (reset_L),
        .data_input  (din10),
        .data_output (dout10),
        .valid_out   (valid10),
        .active      (act10),
        .BC_contador (bc10)
    );

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } pulse_t;

    pulse_t obs_q[$];
    int     valid10_cnt = 0;

    // Reference model: full bit history since reset; word boundaries are every W bits
    // counted from the bit where the first comma was spotted.
    bit         hist[$];
    int         m_origin;
    int         m_commas;
    bit         m_searching;
    bit         m_active;
    logic [7:0] m_data;
    bit         m_valid;

    function automatic logic [7:0] window();
        logic [7:0] w = '0;
        for (int i = 0; i < W; i++) begin
            int idx = hist.size() - W + i;
            if (idx >= 0) w[W-1-i] = hist[idx];
        end
        return w;
    endfunction

    task automatic model_reset();
        hist.delete();
        m_origin    = 0;
        m_commas    = 0;
        m_searching = 1'b1;
        m_active    = 1'b0;
        m_data      = '0;
        m_valid     = 1'b0;
    endtask

    task automatic model_step(input bit b);
        logic [7:0] w;
        int n;
        hist.push_back(b);
        n = hist.size();
        w = window();
        m_valid = 1'b0;
        if (m_searching) begin
            if (w == BC) begin
                m_searching = 1'b0;
                m_origin    = n;
                m_commas    = 1;
                if (LOCK == 1) m_active = 1'b1;
            end
        end else if ((n - m_origin) % W == 0) begin
            if (m_active) begin
                if (w != BC) begin
                    m_data  = w;
                    m_valid = 1'b1;
                end
            end else if (w == BC) begin
                m_commas++;
                if (m_commas == LOCK) m_active = 1'b1;
            end else begin
                m_searching = 1'b1;
                m_commas    = 0;
            end
        end
    endtask

    task automatic send(input bit b, input bit b10);
        din   = b;
        din10 = b10;
        @(posedge clk_32f);
        #1;
        cycle++;
        model_step(b);
        if (valid)   obs_q.push_back('{dout, cycle});
        if (valid10) valid10_cnt++;
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int i = W - 1; i >= 0; i--) send(w[i], 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk_32f);
        reset_L = 1'b0;
        din     = 1'b0;
        din10   = 1'b0;
        #1;
        model_reset();
        obs_q.delete();
        valid10_cnt = 0;
        @(negedge clk_32f);
        reset_L = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk_32f);
        reset_L = 1'b0;
        #1;
        checks++; if (dout   !== 8'h00) begin errors++; $display("FAIL reset_dout got=%h exp=00", dout); end
        checks++; if (valid  !== 1'b0)  begin errors++; $display("FAIL reset_valid got=%b exp=0", valid); end
        checks++; if (act    !== 1'b0)  begin errors++; $display("FAIL reset_active got=%b exp=0", act); end
        checks++; if (bc     !== 4'd0)  begin errors++; $display("FAIL reset_bc got=%0d exp=0", bc); end
        checks++; if (dout10 !== 10'h0) begin errors++; $display("FAIL reset_dout10 got=%h exp=000", dout10); end
        checks++; if (act10  !== 1'b0)  begin errors++; $display("FAIL reset_active10 got=%b exp=0", act10); end
        @(negedge clk_32f);
        reset_L = 1'b1;
    endtask

    task automatic test_lock_data();
        int c5a;
        do_reset();
        for (int k = 0; k < LOCK; k++) begin
            send_word(BC);
            checks++; if (act !== 1'(k == LOCK - 1)) begin errors++; $display("FAIL lock_active comma=%0d got=%b", k + 1, act); end
            checks++; if (bc !== 4'(k + 1)) begin errors++; $display("FAIL lock_bc comma=%0d got=%0d exp=%0d", k + 1, bc, k + 1); end
        end
        send_word(8'h5A);
        c5a = cycle;
        checks++; if (valid !== 1'b1 || dout !== 8'h5A) begin errors++; $display("FAIL latency_5a valid=%b dout=%h exp=1/5a", valid, dout); end
        send_word(8'hC3);
        checks++;
        if (obs_q.size() != 2) begin
            errors++; $display("FAIL pulse_count got=%0d exp=2", obs_q.size());
        end else if (obs_q[0].data !== 8'h5A || obs_q[1].data !== 8'hC3 ||
                     obs_q[0].cyc != c5a || obs_q[1].cyc - obs_q[0].cyc != 8) begin
            errors++;
            $display("FAIL pulse_data got=%h,%h gap=%0d exp=5a,c3 gap=8", obs_q[0].data, obs_q[1].data, obs_q[1].cyc - obs_q[0].cyc);
        end
    endtask

    task automatic test_offset();
        logic [2:0] g;
        do_reset();
        g = 3'($urandom);
        for (int i = 2; i >= 0; i--) send(g[i], 1'b0);
        for (int k = 0; k < LOCK; k++) send_word(BC);
        checks++; if (act !== 1'b1) begin errors++; $display("FAIL offset_active got=%b exp=1", act); end
        send_word(8'h11);
        checks++; if (dout !== 8'h11) begin errors++; $display("FAIL offset_dout got=%h exp=11", dout); end
        checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL offset_pulses got=%0d exp=1", obs_q.size()); end
    endtask

    task automatic test_abort();
        do_reset();
        send_word(BC);
        send_word(BC);
        checks++; if (bc !== 4'd2) begin errors++; $display("FAIL abort_bc_mid got=%0d exp=2", bc); end
        send_word(8'h00);
        checks++; if (bc !== 4'd0) begin errors++; $display("FAIL abort_bc got=%0d exp=0", bc); end
        checks++; if (act !== 1'b0) begin errors++; $display("FAIL abort_active got=%b exp=0", act); end
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL abort_pulses got=%0d exp=0", obs_q.size()); end
    endtask

    task automatic test_idle();
        do_reset();
        for (int k = 0; k < LOCK; k++) send_word(BC);
        send_word(8'hAA);
        send_word(BC);
        checks++; if (dout !== 8'hAA || valid !== 1'b0) begin errors++; $display("FAIL idle_hold dout=%h valid=%b exp=aa/0", dout, valid); end
        checks++; if (bc !== 4'd4) begin errors++; $display("FAIL idle_bc got=%0d exp=4", bc); end
        send_word(8'h77);
        checks++;
        if (obs_q.size() != 2) begin
            errors++; $display("FAIL idle_pulses got=%0d exp=2", obs_q.size());
        end else if (obs_q[0].data !== 8'hAA || obs_q[1].data !== 8'h77) begin
            errors++; $display("FAIL idle_data got=%h,%h exp=aa,77", obs_q[0].data, obs_q[1].data);
        end
        checks++; if (bc !== 4'd4) begin errors++; $display("FAIL idle_bc_data got=%0d exp=4", bc); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        do_reset();
        for (int k = 0; k < LOCK; k++) send_word(BC);
        d = 8'h5A ^ 8'($urandom_range(1, 15));
        send_word(d);
        for (int i = 0; i < 3; i++) send(1'($urandom), 1'b0);
        #2;
        reset_L = 1'b0;
        #1;
        checks++; if (dout !== 8'h00 || valid !== 1'b0 || act !== 1'b0 || bc !== 4'd0) begin
            errors++; $display("FAIL midreset_outputs dout=%h valid=%b act=%b bc=%0d exp=all 0", dout, valid, act, bc);
        end
        model_reset();
        obs_q.delete();
        #1;
        reset_L = 1'b1;
        for (int k = 0; k < LOCK; k++) begin
            send_word(BC);
            checks++; if (act !== 1'(k == LOCK - 1)) begin errors++; $display("FAIL relock_active comma=%0d got=%b", k + 1, act); end
        end
    endtask

    task automatic test_random();
        bit stim[$];
        logic [7:0] w;
        for (int it = 0; it < 8; it++) begin
            do_reset();
            stim.delete();
            repeat ($urandom_range(0, 15)) stim.push_back(1'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                w = 8'($urandom);
                for (int j = 0; j < 2; j++) for (int i = W - 1; i >= 0; i--) stim.push_back(BC[i]);
                for (int i = W - 1; i >= 0; i--) stim.push_back(w[i]);
            end
            repeat (LOCK + $urandom_range(0, 2)) for (int i = W - 1; i >= 0; i--) stim.push_back(BC[i]);
            repeat (30) begin
                int r = $urandom_range(0, 9);
                if (r == 0) begin
                    repeat ($urandom_range(1, 7)) stim.push_back(1'($urandom));
                end else begin
                    w = (r < 3) ? BC : 8'($urandom);
                    for (int i = W - 1; i >= 0; i--) stim.push_back(w[i]);
                end
            end
            foreach (stim[k]) begin
                send(stim[k], 1'b0);
                checks++; if (valid !== m_valid) begin errors++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cycle, valid, m_valid); end
                checks++; if (act !== m_active) begin errors++; $display("FAIL rnd_active cyc=%0d got=%b exp=%b", cycle, act, m_active); end
                checks++; if (bc !== 4'(m_commas)) begin errors++; $display("FAIL rnd_bc cyc=%0d got=%0d exp=%0d", cycle, bc, m_commas); end
                checks++; if (dout !== m_data) begin errors++; $display("FAIL rnd_dout cyc=%0d got=%h exp=%h", cycle, dout, m_data); end
            end
        end
    endtask

    task automatic test_w10();
        logic [9:0] c;
        logic [9:0] d;
        c = 10'h17C;
        d = 10'h2A5;
        do_reset();
        for (int i = 9; i >= 0; i--) send(1'b0, c[i]);
        checks++; if (act10 !== 1'b1 || bc10 !== 4'd1) begin errors++; $display("FAIL w10_lock act=%b bc=%0d exp=1/1", act10, bc10); end
        for (int i = 9; i >= 0; i--) send(1'b0, d[i]);
        checks++; if (valid10 !== 1'b1 || dout10 !== 10'h2A5) begin errors++; $display("FAIL w10_data valid=%b dout=%h exp=1/2a5", valid10, dout10); end
        send(1'b0, 1'b0);
        checks++; if (valid10 !== 1'b0 || valid10_cnt != 1) begin errors++; $display("FAIL w10_strobe valid=%b pulses=%0d exp=0/1", valid10, valid10_cnt); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_lock_data();
        test_offset();
        test_abort();
        test_idle();
        test_reset_mid();
        test_random();
        test_w10();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_paralelo_param.md
SERIAL_PARALELO_PARAM -- requirements
Module: serial_paralelo_param

Interface
REQ-001 Parameter WIDTH, default 8: parallel word width in bits; legal range 4..16.
REQ-002 Parameter COMMA, default 8'hBC (WIDTH bits): alignment symbol.
REQ-003 Parameter LOCK_COUNT, default 4: consecutive aligned commas required to go active; legal range 1..15.
REQ-004 Port clk_32f, input, 1 bit: the single serial bit clock; all logic is rising-edge.
REQ-005 Port reset_L, input, 1 bit: asynchronous active-low reset.
REQ-006 Port data_input, input, 1 bit: serial data, MSB first, sampled each clk_32f rising edge.
REQ-007 Port data_output, output, WIDTH bits: last accepted parallel word.
REQ-008 Port valid_out, output, 1 bit: one-cycle strobe marking a new non-comma word on data_output.
REQ-009 Port active, output, 1 bit: high while the link is locked.
REQ-010 Port BC_contador, output, 4 bits: consecutive aligned comma count, saturating at LOCK_COUNT.

Function
REQ-011 Shift register sr SHALL load {sr[WIDTH-2:0], data_input} on every clock edge; next_sr denotes this value.
REQ-012 FSM states: SEARCH, ALIGN, ACTIVE.
REQ-013 SEARCH: next_sr compared to COMMA every cycle (bit-granular); on match -> ALIGN, bit counter set to 0, BC_contador set to 1.
REQ-014 Bit counter counts 0..WIDTH-1 and wraps; a word boundary is the edge where the counter is WIDTH-1 in ALIGN/ACTIVE.
REQ-015 ALIGN: at boundary, next_sr == COMMA -> BC_contador increments; if it reaches LOCK_COUNT -> ACTIVE and active=1 on that same edge.
REQ-016 ALIGN: at boundary, next_sr != COMMA -> SEARCH, BC_contador cleared to 0.
REQ-017 LOCK_COUNT=1: the SEARCH match itself SHALL go directly to ACTIVE.
REQ-018 ACTIVE: at boundary, next_sr != COMMA -> data_output <= next_sr and valid_out=1 for exactly one cycle.
REQ-019 ACTIVE: at boundary, next_sr == COMMA -> idle symbol; data_output holds, valid_out=0, BC_contador saturates at LOCK_COUNT.
REQ-020 ACTIVE: BC_contador SHALL NOT decrement on data words; it keeps its saturated value.
REQ-021 ACTIVE is left only by reset; misaligned comma patterns inside data are ignored.
REQ-022 Latency: a word is on data_output, with valid_out high, in the cycle after the edge that samples its last bit, i.e. zero extra register stages.
REQ-023 valid_out SHALL never be high in SEARCH or ALIGN, nor on two consecutive cycles when WIDTH > 1.
REQ-024 All outputs SHALL be registered.

Reset
REQ-025 reset_L low asynchronously forces: state SEARCH, sr 0, bit counter 0, data_output 0, valid_out 0, active 0, BC_contador 0.
REQ-026 Reset asserted mid-word or mid-lock SHALL discard the partial word; relock requires the full LOCK_COUNT sequence again.
REQ-027 Deassertion is synchronous to the first clk_32f edge; that edge already samples data_input.

Structure
REQ-028 A shared package/header holds the state encodings (SEARCH=2'd0, ALIGN=2'd1, ACTIVE=2'd2) and the default COMMA constant.
REQ-029 One sub-module, sp_comma_det (WIDTH, COMMA), holds sr plus the comma comparator; the FSM, counters and output registers sit in the top.

Verification (WIDTH=8, COMMA=8'hBC, LOCK_COUNT=4)
REQ-030 4x BC aligned, then 8'h5A, 8'hC3 -> active=1 after the 4th BC; valid_out pulses with data_output=5A then C3, 8 cycles apart.
REQ-031 3 garbage bits, then 4x BC, then 8'h11 -> lock at 3-bit offset; data_output=11 with a single valid_out pulse.
REQ-032 BC, BC, 8'h00 -> SEARCH with BC_contador=0; no valid_out; active stays 0.
REQ-033 Locked, stream 8'hAA, BC, 8'h77 -> valid_out for AA and 77 only; data_output holds AA during the BC word; BC_contador=4.
REQ-034 reset_L pulsed low mid-word while ACTIVE -> all outputs 0 immediately; the next 3x BC do not lock, and the 4th BC locks.
REQ-035 WIDTH=10, COMMA=10'h17C, LOCK_COUNT=1: a single 17C followed by 10'h2A5 -> active after the first comma; data_output=2A5 with valid_out.
